// File: rtl/async_fifo_rd_drain_if.sv
// async_fifo_rd_drain_if: valid/ready output stream carrying drained FIFO words, last-beat and checksum-beat markers
interface async_fifo_rd_drain_if #(parameter int DSIZE = 8);
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             m_csum;
  modport master(output m_data, m_valid, m_last, m_csum, input m_ready);
  modport slave(input m_data, m_valid, m_last, m_csum, output m_ready);
endinterface

// File: rtl/async_fifo_rd_drain.sv
// async_fifo_rd_drain: paced read-side FIFO drain into BURST_LEN bursts; RD_DRAIN_BURST_CSUM_EN appends an XOR checksum beat
module async_fifo_rd_drain #(
  parameter int DSIZE       = 8,
  parameter int BURST_LEN   = 512,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   en,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  async_fifo_rd_drain_if.master  m,
  output logic                   busy,
  output logic [15:0]            burst_cnt
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int GW = IDLE_CYCLES > 1 ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(IDLE_CYCLES > 0 ? IDLE_CYCLES - 1 : 0);
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
`ifdef RD_DRAIN_BURST_CSUM_EN
    GAP,
    CSUM
`else
    GAP
`endif
  } state_t;
`ifdef RD_DRAIN_BURST_CSUM_EN
  localparam bit     CSUM_EN = 1'b1;
  localparam state_t END_ST  = CSUM;
`else
  localparam bit     CSUM_EN = 1'b0;
  localparam state_t END_ST  = IDLE;
`endif
  state_t        state, state_nxt;
  logic [BW-1:0] beat;
  logic [GW-1:0] gap;
  logic          free, accept, pop, final_pop;
  assign free      = !m.m_valid || m.m_ready;
  assign accept    = m.m_valid && m.m_ready;
  assign pop       = rinc;
  assign final_pop = pop && beat == LAST_BEAT;
  always_ff @(posedge rclk)
    if (rrst) state <= IDLE;
    else      state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = en ? FETCH : IDLE;
      FETCH: state_nxt = !pop ? FETCH : final_pop ? END_ST : IDLE_CYCLES > 0 ? GAP : FETCH;
      GAP:   state_nxt = gap == GAP_MAX ? FETCH : GAP;
`ifdef RD_DRAIN_BURST_CSUM_EN
      CSUM:  state_nxt = accept && m.m_csum ? IDLE : CSUM;
`endif
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    rinc = state == FETCH && !rempty && free && !rrst;
    busy = state != IDLE || (m.m_valid && m.m_last);
  end
  always_ff @(posedge rclk)
    if (rrst) gap <= '0;
    else      gap <= state == GAP ? gap + 1'b1 : '0;
  always_ff @(posedge rclk)
    if (rrst || (state == IDLE && en)) beat <= '0;
    else if (pop)                      beat <= beat + 1'b1;
`ifdef RD_DRAIN_BURST_CSUM_EN
  logic [DSIZE-1:0] acc;
  logic             csum_load;
  // the checksum beat loads once, into a free register, while the data word still pending is being accepted
  assign csum_load = state == CSUM && !m.m_csum && free;
  always_ff @(posedge rclk)
    if (rrst || (state == IDLE && en)) acc <= '0;
    else if (pop)                      acc <= acc ^ rdata;
  always_ff @(posedge rclk)
    if (rrst)           m.m_csum <= 1'b0;
    else if (pop)       m.m_csum <= 1'b0;
    else if (csum_load) m.m_csum <= 1'b1;
    else if (accept)    m.m_csum <= 1'b0;
`else
  logic csum_load;
  assign csum_load = 1'b0;
  assign m.m_csum  = 1'b0;
`endif
  always_ff @(posedge rclk)
    if (rrst) begin
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_last  <= 1'b0;
    end else if (pop) begin
      m.m_valid <= 1'b1;
      m.m_data  <= rdata;
      m.m_last  <= final_pop && !CSUM_EN;
    end else if (csum_load) begin
      m.m_valid <= 1'b1;
`ifdef RD_DRAIN_BURST_CSUM_EN
      m.m_data  <= acc;
`endif
      m.m_last  <= 1'b1;
    end else if (accept) begin
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_last  <= 1'b0;
    end
  always_ff @(posedge rclk)
    if (rrst)                     burst_cnt <= '0;
    else if (accept && m.m_last)  burst_cnt <= burst_cnt + 16'd1;
endmodule
